id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
//  Captures decoded instructions from ID and drives the ALU operand/control inputs
//  (SrcA, SrcB, ALUctrl, BranchCtrl, shift) plus control bits that travel on to EX/MEM.
//  Inserts one-cycle bubbles on load-use hazards and on branch flush.
// PARAMETERS
//  DATAWIDTH      32  datapath width
//  SHIFT_WIDTH    5   shift-amount width; shift_o = SrcB_o[SHIFT_WIDTH-1:0]
//  REG_ADDR_WIDTH 5   register index width
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   reset, asynchronous, active-low
//  id_valid_i       in   1   ID holds a real instruction
//  rs1_addr_i       in   RA  source register 1 index
//  rs2_addr_i       in   RA  source register 2 index
//  rd_addr_i        in   RA  destination register index
//  rs1_data_i       in   DW  register-file read data 1
//  rs2_data_i       in   DW  register-file read data 2
//  imm_i            in   DW  sign-extended immediate
//  pc_i             in   DW  instruction PC
//  ALUSrcA_i        in   1   0: rs1, 1: pc
//  ALUSrcB_i        in   1   0: rs2, 1: imm
//  ALUctrl_i        in   4   ALU operation
//  BranchCtrl_i     in   3   branch condition
//  RegWrite_i       in   1   instruction writes rd
//  MemRead_i        in   1   instruction is a load
//  MemWrite_i       in   1   instruction is a store
//  exmem_rd_i       in   RA  EX/MEM destination
//  exmem_regwrite_i in   1   EX/MEM writes rd
//  exmem_result_i   in   DW  EX/MEM ALU result
//  memwb_rd_i       in   RA  MEM/WB destination
//  memwb_regwrite_i in   1   MEM/WB writes rd
//  memwb_result_i   in   DW  MEM/WB writeback value
//  flush_i          in   1   branch taken in EX; kill the instruction entering EX
//  SrcA_o           out  DW  ALU operand A (forwarded)
//  SrcB_o           out  DW  ALU operand B (forwarded)
//  ALUctrl_o        out  4   registered ALUctrl
//  BranchCtrl_o     out  3   registered BranchCtrl
//  shift_o          out  SW  SrcB_o[SW-1:0]
//  StoreData_o      out  DW  forwarded rs2 value for stores
//  pc_o             out  DW  registered PC
//  rd_addr_o        out  RA  registered rd
//  ex_valid_o       out  1   EX stage holds a real instruction
//  RegWrite_o       out  1   registered RegWrite, gated by ex_valid
//  MemRead_o        out  1   registered MemRead, gated by ex_valid
//  MemWrite_o       out  1   registered MemWrite, gated by ex_valid
//  stall_o          out  1   combinational; PC and IF/ID must hold this cycle
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): all registered state <= 0. ex_valid_o=0; all control outputs 0.
//  - Register update each rising edge, in priority order:
//    1. flush_i=1: load a bubble (valid=0, RegWrite/MemRead/MemWrite/ALUctrl/BranchCtrl=0).
//    2. stall_o=1: load a bubble.
//    3. Otherwise: capture all ID inputs; valid <= id_valid_i.
//  - Load-use: stall_o = ex_valid & MemRead_reg & rd_reg!=0 & id_valid_i & ~flush_i
//      & (rd_reg==rs1_addr_i | rd_reg==rs2_addr_i).
//    - Stall lasts exactly 1 cycle; the load then sits in MEM/WB and is forwarded.
//    - flush_i suppresses stall_o.
//  - Forwarding: applied combinationally after the register, separately to rs1 and rs2.
//    - EX/MEM match (regwrite & rd!=0 & rd==rsX_reg) takes priority over a MEM/WB match.
//    - Otherwise the registered register-file data is used. x0 is never forwarded.
//  - SrcA_o = ALUSrcA_reg ? pc_reg : fwd_rs1. SrcB_o = ALUSrcB_reg ? imm_reg : fwd_rs2.
//  - StoreData_o = fwd_rs2, always.
//  - Same-cycle WB write/ID read bypass is the register file's responsibility, not this block's.
//  - Operand outputs may carry stale data when ex_valid_o=0; all write/memory controls are forced 0.
//  - Latency: ID to ALU inputs is 1 cycle. Forwarding adds 0 cycles.
// TESTING
//  1. rst_n low mid-operation -> all outputs 0 immediately (async), ex_valid_o=0.
//  2. ADD x3,x1,x2 then ADD x4,x3,x3 back-to-back, EX/MEM result 0x10 -> SrcA_o=SrcB_o=0x10.
//  3. EX/MEM and MEM/WB both rd=5 (0xAA / 0xBB), EX rs1=5 -> SrcA_o=0xAA (EX/MEM wins).
//  4. LW x7 in EX, ID reads x7 -> stall_o=1 for 1 cycle, bubble (ex_valid_o=0);
//     next cycle MEM/WB=0x55 -> SrcA_o=0x55.
//  5. flush_i=1 together with a load-use hazard -> stall_o=0, next ex_valid_o=0, RegWrite_o=0.
//  6. Write to x0 in EX/MEM (result 0xFF), EX rs1=0 -> SrcA_o=rs1_data (0), not 0xFF.
//     ALUSrcB=1, imm=0x23 -> shift_o=3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with EX-side operand forwarding and load-use
//   hazard detection. A decoded instruction from ID is captured on each
//   rising edge. Its operands are then resolved against the EX/MEM and
//   MEM/WB producers to form the ALU inputs.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid_i                 ID holds a real instruction
//   rs1/rs2/rd_addr_i          register indices of the ID instruction
//   rs1/rs2_data_i             register-file read data
//   imm_i, pc_i                immediate and PC of the ID instruction
//   ALUSrcA_i / ALUSrcB_i      operand select (pc / imm)
//   ALUctrl_i, BranchCtrl_i    ALU operation and branch condition
//   RegWrite_i/MemRead_i/MemWrite_i   control bits travelling to EX/MEM
//   exmem_* / memwb_*          producers used for forwarding
//   flush_i                    kill the instruction entering EX
//   SrcA_o, SrcB_o, shift_o    ALU operands and shift amount
//   StoreData_o                forwarded rs2 for stores
//   ALUctrl_o, BranchCtrl_o, pc_o, rd_addr_o   registered fields
//   ex_valid_o, RegWrite_o, MemRead_o, MemWrite_o   gated controls
//   stall_o                    combinational load-use stall for PC and IF/ID
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATAWIDTH      = 32,
  parameter int SHIFT_WIDTH    = 5,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATAWIDTH-1:0]      rs1_data_i,
  input  logic [DATAWIDTH-1:0]      rs2_data_i,
  input  logic [DATAWIDTH-1:0]      imm_i,
  input  logic [DATAWIDTH-1:0]      pc_i,
  input  logic                      ALUSrcA_i,
  input  logic                      ALUSrcB_i,
  input  logic [3:0]                ALUctrl_i,
  input  logic [2:0]                BranchCtrl_i,
  input  logic                      RegWrite_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      exmem_regwrite_i,
  input  logic [DATAWIDTH-1:0]      exmem_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                      memwb_regwrite_i,
  input  logic [DATAWIDTH-1:0]      memwb_result_i,
  input  logic                      flush_i,
  output logic [DATAWIDTH-1:0]      SrcA_o,
  output logic [DATAWIDTH-1:0]      SrcB_o,
  output logic [3:0]                ALUctrl_o,
  output logic [2:0]                BranchCtrl_o,
  output logic [SHIFT_WIDTH-1:0]    shift_o,
  output logic [DATAWIDTH-1:0]      StoreData_o,
  output logic [DATAWIDTH-1:0]      pc_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      ex_valid_o,
  output logic                      RegWrite_o,
  output logic                      MemRead_o,
  output logic                      MemWrite_o,
  output logic                      stall_o
);

  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATAWIDTH-1:0]      rs1_data_q;
  logic [DATAWIDTH-1:0]      rs2_data_q;
  logic [DATAWIDTH-1:0]      imm_q;
  logic [DATAWIDTH-1:0]      pc_q;
  logic                      alu_src_a_q;
  logic                      alu_src_b_q;
  logic [3:0]                alu_ctrl_q;
  logic [2:0]                branch_ctrl_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;

  logic                      rs_hit;
  logic [DATAWIDTH-1:0]      fwd_rs1;
  logic [DATAWIDTH-1:0]      fwd_rs2;

  // Load-use hazard: a load in EX whose destination the ID instruction reads.
  // The consumer is held for one cycle; by then the load sits in MEM/WB and
  // the forwarding network supplies it. A flush overrides the stall because
  // the consumer is being killed anyway.
  always_comb begin
    rs_hit  = (rd_q == rs1_addr_i) || (rd_q == rs2_addr_i);
    stall_o = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
              !flush_i && rs_hit;
  end

  // Pipeline register. Bubbles clear only the control fields; operand data is
  // left stale since every side-effecting output is gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      alu_src_a_q   <= 1'b0;
      alu_src_b_q   <= 1'b0;
      alu_ctrl_q    <= '0;
      branch_ctrl_q <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else if (flush_i || stall_o) begin
      valid_q       <= 1'b0;
      alu_ctrl_q    <= '0;
      branch_ctrl_q <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= id_valid_i;
      rs1_addr_q    <= rs1_addr_i;
      rs2_addr_q    <= rs2_addr_i;
      rd_q          <= rd_addr_i;
      rs1_data_q    <= rs1_data_i;
      rs2_data_q    <= rs2_data_i;
      imm_q         <= imm_i;
      pc_q          <= pc_i;
      alu_src_a_q   <= ALUSrcA_i;
      alu_src_b_q   <= ALUSrcB_i;
      alu_ctrl_q    <= ALUctrl_i;
      branch_ctrl_q <= BranchCtrl_i;
      reg_write_q   <= RegWrite_i;
      mem_read_q    <= MemRead_i;
      mem_write_q   <= MemWrite_i;
    end
  end

  // Forwarding: the younger EX/MEM producer wins over MEM/WB. x0 is hardwired
  // to zero, so a "write" to it must never be forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_addr_q))
      fwd_rs1 = exmem_result_i;
    else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_addr_q))
      fwd_rs1 = memwb_result_i;

    fwd_rs2 = rs2_data_q;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_addr_q))
      fwd_rs2 = exmem_result_i;
    else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_addr_q))
      fwd_rs2 = memwb_result_i;
  end

  // Operand muxes and gated controls.
  always_comb begin
    SrcA_o       = alu_src_a_q ? pc_q : fwd_rs1;
    SrcB_o       = alu_src_b_q ? imm_q : fwd_rs2;
    shift_o      = SrcB_o[SHIFT_WIDTH-1:0];
    StoreData_o  = fwd_rs2;
    ALUctrl_o    = alu_ctrl_q;
    BranchCtrl_o = branch_ctrl_q;
    pc_o         = pc_q;
    rd_addr_o    = rd_q;
    ex_valid_o   = valid_q;
    RegWrite_o   = valid_q && reg_write_q;
    MemRead_o    = valid_q && mem_read_q;
    MemWrite_o   = valid_q && mem_write_q;
  end

endmodule
